spi_master_tx: RTL and testbench

SPI initiator that serialises bytes onto `sck`/`cs`/`mosi` for the controller's SPI byte receiver, which lives downstream on the same link. It sends mode 0, MSB first: `mosi` is stable before each `sck` rising edge, and `sck` idles low. A byte is accepted through a valid/ready handshake. The block produces one `done` pulse per byte, timed after the final falling `sck` edge so the receiver has already raised its ready flag.

---
 rtl/spi_master_tx_if.sv | 21 ++
 rtl/spi_master_tx.sv | 155 +++++++++++++++
 tb/tb_spi_master_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_if.sv
// Byte handshake and SPI pin bundle for spi_master_tx.
// master = byte source / link observer side, slave = the serialiser itself.
interface spi_master_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sck;
  logic       cs;
  logic       mosi;
  logic       done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, sck, cs, mosi, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, sck, cs, mosi, done
  );
endinterface

// File: rtl/spi_master_tx.sv
// Mode-0, MSB-first SPI byte serialiser with valid/ready input and a done pulse.
// Optional back-to-back bytes without a cs gap when SPI_MASTER_BURST_EN is defined.
//
// state | meaning
// IDLE  | waiting for a byte, tx_ready high
// LEAD  | cs low, bit 7 on mosi, waiting for the first rising sck
// HIGH  | sck high half-period
// LOW   | sck low half-period between bits
// TRAIL | final low half-period after the last falling sck
// GAP   | cs high recovery before accepting the next byte
module spi_master_tx #(
  parameter int CLK_DIV = 8,
  parameter int CS_GAP  = 4
) (
  input logic           clk,
  input logic           reset,
  spi_master_tx_if.slave bus
);
  localparam int DMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int DW   = $clog2(DMAX);
  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_TC = DW'(CS_GAP - 1);
`ifdef SPI_MASTER_BURST_EN
  localparam logic [DW-1:0] PRE_TC = DW'(CLK_DIV - 2);
`endif

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;
  logic          tx_ready_q, tx_ready_d;
  logic          load;
  logic          accept;

  assign accept = bus.tx_valid & tx_ready_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    div_d      = div_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    tx_ready_d = tx_ready_q;
    load       = 1'b0;

    case (state_q)
      IDLE: load = accept;
      LEAD, LOW: begin
        if (div_q == DIV_TC) begin
          sck_d   = 1'b1;
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_q == DIV_TC) begin
          sck_d = 1'b0;
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TRAIL;
          end else begin
            bit_d   = bit_q + 1'b1;
            sr_d    = sr_q << 1;
            mosi_d  = sr_q[6];
            state_d = LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      TRAIL: begin
`ifdef SPI_MASTER_BURST_EN
        // ready is registered, so raise it one cycle early to be visible in the last TRAIL cycle
        if (div_q == PRE_TC) tx_ready_d = 1'b1;
`endif
        if (div_q == DIV_TC) begin
          done_d     = 1'b1;
          tx_ready_d = 1'b0;
`ifdef SPI_MASTER_BURST_EN
          load = accept;
`endif
          if (!load) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            div_d   = '0;
            state_d = GAP;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_q == GAP_TC) begin
          div_d      = '0;
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d       = bus.tx_data;
      mosi_d     = bus.tx_data[7];
      cs_d       = 1'b0;
      bit_d      = '0;
      div_d      = '0;
      tx_ready_d = 1'b0;
      state_d    = LEAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.sck      = sck_q;
  assign bus.cs       = cs_q;
  assign bus.mosi     = mosi_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: two instances (CLK_DIV 8/CS_GAP 4 and 4/1),
// a receiver-style monitor per instance checks byte content and done timing.
module tb_spi_master_tx;
  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         acc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] data_s [2];
  logic [1:0] valid_s;
  logic [1:0] rdy, cs_o, sck_o, mosi_o, done_o;

  spi_master_tx_if ifa();
  spi_master_tx_if ifb();

  spi_master_tx #(.CLK_DIV(8), .CS_GAP(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  spi_master_tx #(.CLK_DIV(4), .CS_GAP(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  assign ifa.tx_data  = data_s[0];
  assign ifa.tx_valid = valid_s[0];
  assign ifb.tx_data  = data_s[1];
  assign ifb.tx_valid = valid_s[1];
  assign rdy[0]    = ifa.tx_ready;
  assign rdy[1]    = ifb.tx_ready;
  assign cs_o[0]   = ifa.cs;
  assign cs_o[1]   = ifb.cs;
  assign sck_o[0]  = ifa.sck;
  assign sck_o[1]  = ifb.sck;
  assign mosi_o[0] = ifa.mosi;
  assign mosi_o[1] = ifb.mosi;
  assign done_o[0] = ifa.done;
  assign done_o[1] = ifb.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cd(input int s);
    return (s == 0) ? 8 : 4;
  endfunction

  function automatic int cg(input int s);
    return (s == 0) ? 4 : 1;
  endfunction

  function automatic int rdy_lat(input int s);
`ifdef SPI_MASTER_BURST_EN
    return 17 * cd(s) - 1;
`else
    return 17 * cd(s) + cg(s);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Receiver-side monitor: shifts mosi on rising sck while cs low, checks on done.
  task automatic monitor(input int s);
    logic       psck = 1'b0;
    logic       pmosi = 1'b0;
    logic       pcs = 1'b1;
    logic       pdone = 1'b0;
    logic [7:0] shreg = 8'h00;
    int         nb = 0;
    int         lowc = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!cs_o[s]) begin
        if (pcs) begin
          nb   = 0;
          lowc = 0;
        end
        lowc++;
        if (sck_o[s] && !psck) begin
          shreg = {shreg[6:0], mosi_o[s]};
          nb++;
        end
        if (!pcs && !done_o[s] && (mosi_o[s] != pmosi))
          chk($sformatf("mosi_edge%0d", s), int'(psck && !sck_o[s]), 1);
      end
      if (done_o[s]) begin
        chk($sformatf("done_width%0d", s), int'(pdone), 0);
        if (sb.size() == 0) begin
          chk($sformatf("done_spurious%0d", s), 1, 0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb_inst%0d", s), e.inst, s);
          chk($sformatf("rx_byte%0d", s), int'(shreg), int'(e.data));
          chk($sformatf("rx_bits%0d", s), nb, 8);
          chk($sformatf("done_time%0d", s), cyc - e.acc, 17 * cd(s));
          if (cs_o[s]) chk($sformatf("cs_low%0d", s), lowc, 17 * cd(s));
        end
        nb = 0;
        lowc = 0;
      end
      psck  = sck_o[s];
      pmosi = mosi_o[s];
      pcs   = cs_o[s];
      pdone = done_o[s];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int s, input logic [7:0] d, input int glitch_at, input int reset_at);
    int   n;
    exp_t e;
    n = 0;
    while (!rdy[s] && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", int'(rdy[s]), 1);
    data_s[s]  = d;
    valid_s[s] = 1'b1;
    @(posedge clk); #1;
    valid_s[s] = 1'b0;
    data_s[s]  = ~d;
    if (reset_at < 0) begin
      e.inst = s;
      e.data = d;
      e.acc  = cyc;
      sb.push_back(e);
    end
    chk("ready_drop", int'(rdy[s]), 0);
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (n == glitch_at) begin
        data_s[s]  = 8'h11;
        valid_s[s] = 1'b1;
      end
      if (n == glitch_at + 1) begin
        valid_s[s] = 1'b0;
        data_s[s]  = ~d;
      end
      if (n == reset_at) begin
        #3 reset = 1'b1;
        #1;
        chk("rst_cs", int'(cs_o[s]), 1);
        chk("rst_sck", int'(sck_o[s]), 0);
        chk("rst_mosi", int'(mosi_o[s]), 0);
        chk("rst_ready", int'(rdy[s]), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      if (rdy[s]) break;
    end
    chk("ready_latency", n, rdy_lat(s));
  endtask

`ifdef SPI_MASTER_BURST_EN
  task automatic burst();
    logic [7:0] b [3];
    int         i;
    int         n;
    logic       r;
    exp_t       e;
    b[0] = 8'h01;
    b[1] = 8'h80;
    b[2] = 8'h7E;
    i = 0;
    n = 0;
    data_s[0]  = b[0];
    valid_s[0] = 1'b1;
    while (i < 3 && n < 3000) begin
      r = rdy[0];
      @(posedge clk); #1;
      n++;
      if (r) begin
        e.inst = 0;
        e.data = b[i];
        e.acc  = cyc;
        sb.push_back(e);
        i++;
        if (i < 3) data_s[0] = b[i];
        else valid_s[0] = 1'b0;
      end
    end
    valid_s[0] = 1'b0;
    chk("burst_accepts", i, 3);
  endtask
`endif

  initial begin
    int n;
    data_s[0] = 8'h00;
    data_s[1] = 8'h00;
    valid_s   = 2'b00;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_cs", int'(cs_o[s]), 1);
      chk("reset_sck", int'(sck_o[s]), 0);
      chk("reset_mosi", int'(mosi_o[s]), 0);
      chk("reset_done", int'(done_o[s]), 0);
      chk("reset_ready", int'(rdy[s]), 1);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    send(0, 8'hA5, -1, -1);
    send(0, 8'h3C, -1, -1);
    send(0, 8'hFF, -1, -1);
    send(0, 8'h5A, 40, -1);
    send(0, 8'hF0, -1, 50);
    send(0, 8'h0F, -1, -1);
    send(1, 8'h00, -1, -1);
    send(1, 8'hFF, -1, -1);
`ifdef SPI_MASTER_BURST_EN
    repeat (200) @(posedge clk);
    #1;
    burst();
`endif

    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
